// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: reset/bubble constants, instruction
// field positions used by the control decoder, and the IF/ID bundle type.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
    // sll $0,$0,0 -- a bubble decodes as a harmless instruction
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_id_t;

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter with next-PC selection: redirect target, hold, or PC+4.
import mips_pkg::*;

module pc_reg #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    input  logic        advance_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + 32'd4;

    // Next-PC mux: redirect beats stall; a wait state holds the PC.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            // Targets are word aligned by construction; the low bits are dropped.
            pc_d = redirect_pc_i & ~32'h0000_0003;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (advance_i) begin
            pc_d = pc_plus4_o;
        end
    end

    // PC register with synchronous reset to the boot vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus the IF/ID pipeline register. No delay slot: a redirect
// squashes whatever was fetched in the same cycle, costing one bubble.
import mips_pkg::*;

module if_id_stage #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_req_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [5:0]  id_opcode_o,
    output logic [5:0]  id_funct_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetched;
    if_id_t      id_q;
    if_id_t      id_d;

    assign fetched = imem_ready_i & ~rst;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .advance_i     (fetched),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4)
    );

    assign imem_addr_o = pc;
    assign imem_req_o  = ~rst;

    // IF/ID next value: squash on redirect, hold on stall, load on fetch, else bubble.
    always_comb begin
        id_d = id_q;
        if (redirect_i) begin
            id_d.valid = 1'b0;
            id_d.instr = NOP_INSTR;
        end else if (stall_i) begin
            id_d = id_q;
        end else if (fetched) begin
            id_d.valid = 1'b1;
            id_d.instr = imem_rdata_i;
            id_d.pc    = pc;
            id_d.pc4   = pc_plus4;
        end else begin
            id_d.valid = 1'b0;
            id_d.instr = NOP_INSTR;
        end
    end

    // IF/ID register with synchronous reset to an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q.valid <= 1'b0;
            id_q.instr <= NOP_INSTR;
            id_q.pc    <= 32'h0;
            id_q.pc4   <= 32'h0;
        end else begin
            id_q <= id_d;
        end
    end

    assign id_valid_o  = id_q.valid;
    assign id_instr_o  = id_q.instr;
    assign id_opcode_o = id_q.instr[OPCODE_MSB:OPCODE_LSB];
    assign id_funct_o  = id_q.instr[FUNCT_MSB:FUNCT_LSB];
    assign id_pc_o     = id_q.pc;
    assign id_pc4_o    = id_q.pc4;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a scoreboard of expected IF/ID contents.
import mips_pkg::*;

module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic        imem_req_o;
    logic [31:0] imem_rdata_i;
    logic        imem_ready_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [5:0]  id_opcode_o;
    logic [5:0]  id_funct_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;

    int n_vec = 0;
    int n_err = 0;

    if_id_t      sb_q[$];
    logic [31:0] model_pc;
    if_id_t      model_id;
    logic        model_known = 1'b0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_req_o    (imem_req_o),
        .imem_rdata_i  (imem_rdata_i),
        .imem_ready_i  (imem_ready_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_opcode_o   (id_opcode_o),
        .id_funct_o    (id_funct_o),
        .id_pc_o       (id_pc_o),
        .id_pc4_o      (id_pc4_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_300C) return 32'h8C22_0004;
        return a ^ 32'hDEAD_0000 ^ {a[7:0], 24'h0};
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check fetch side, predict IF/ID, compare after the edge.
    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [31:0] rpc, input logic rdy);
        logic [31:0] npc;
        if_id_t      nid;
        if_id_t      got;
        @(negedge clk);
        rst = r; stall_i = s; redirect_i = rd; redirect_pc_i = rpc; imem_ready_i = rdy;
        #1;
        chk("imem_req", {31'h0, imem_req_o}, {31'h0, ~r});
        if (model_known && !r) chk("imem_addr", imem_addr_o, model_pc);
        npc = model_pc;
        nid = model_id;
        if (r) begin
            npc = 32'h0000_3000;
            nid = '{1'b0, 32'h0, 32'h0, 32'h0};
        end else if (rd) begin
            npc = {rpc[31:2], 2'b00};
            nid.valid = 1'b0;
            nid.instr = 32'h0;
        end else if (s) begin
            // hold everything
        end else if (rdy) begin
            nid = '{1'b1, mem_word(model_pc), model_pc, model_pc + 32'd4};
            npc = model_pc + 32'd4;
        end else begin
            nid.valid = 1'b0;
            nid.instr = 32'h0;
        end
        sb_q.push_back(nid);
        @(posedge clk);
        #1;
        model_pc    = npc;
        model_id    = nid;
        model_known = 1'b1;
        got = sb_q.pop_front();
        chk("id_valid",  {31'h0, id_valid_o}, {31'h0, got.valid});
        chk("id_instr",  id_instr_o, got.instr);
        chk("id_opcode", {26'h0, id_opcode_o}, {26'h0, got.instr[31:26]});
        chk("id_funct",  {26'h0, id_funct_o}, {26'h0, got.instr[5:0]});
        chk("id_pc",     id_pc_o, got.pc);
        chk("id_pc4",    id_pc4_o, got.pc4);
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_ready_i = 1'b1;

        // Reset
        step(1, 0, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 1);
        chk("rst_addr",  imem_addr_o, 32'h0000_3000);
        chk("rst_valid", {31'h0, id_valid_o}, 32'h0);

        // Stream from reset: 3000, 3004, 3008, 300C
        step(0, 0, 0, 32'h0, 1);
        chk("first_valid", {31'h0, id_valid_o}, 32'h1);
        chk("first_pc",    id_pc_o, 32'h0000_3000);
        chk("first_pc4",   id_pc4_o, 32'h0000_3004);
        chk("seq_addr1",   imem_addr_o, 32'h0000_3004);
        step(0, 0, 0, 32'h0, 1);
        chk("seq_addr2",   imem_addr_o, 32'h0000_3008);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        chk("lw_in_id",    id_instr_o, 32'h8C22_0004);

        // Three-cycle load-use stall
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'h0, 1);
            chk("stall_instr", id_instr_o, 32'h8C22_0004);
            chk("stall_pc",    id_pc_o, 32'h0000_300C);
            chk("stall_addr",  imem_addr_o, 32'h0000_3010);
        end

        // Redirect while fetching 0x3010, unaligned target
        step(0, 0, 1, 32'h0000_3103, 1);
        chk("redir_addr",  imem_addr_o, 32'h0000_3100);
        chk("redir_valid", {31'h0, id_valid_o}, 32'h0);
        chk("redir_instr", id_instr_o, 32'h0);
        step(0, 0, 0, 32'h0, 1);
        chk("target_instr", id_instr_o, mem_word(32'h0000_3100));
        chk("target_pc",    id_pc_o, 32'h0000_3100);

        // Redirect and stall together: redirect wins
        step(0, 1, 1, 32'h0000_3020, 1);
        chk("both_addr",  imem_addr_o, 32'h0000_3020);
        chk("both_valid", {31'h0, id_valid_o}, 32'h0);

        // Two wait states at 0x3020
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        chk("wait_addr",  imem_addr_o, 32'h0000_3020);
        chk("wait_valid", {31'h0, id_valid_o}, 32'h0);
        step(0, 0, 0, 32'h0, 1);
        chk("wait_deliver_pc", id_pc_o, 32'h0000_3020);

        // Reset in the middle of a stall
        step(0, 1, 0, 32'h0, 1);
        step(1, 1, 0, 32'h0, 1);
        chk("midrst_addr",  imem_addr_o, 32'h0000_3000);
        chk("midrst_valid", {31'h0, id_valid_o}, 32'h0);
        step(0, 0, 0, 32'h0, 1);
        chk("after_rst_pc", id_pc_o, 32'h0000_3000);

        // Wrap at top of address space
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 32'h0, 1);
        chk("wrap_addr", imem_addr_o, 32'h0000_0000);
        chk("wrap_pc4",  id_pc4_o, 32'h0000_0000);
        step(0, 0, 0, 32'h0, 1);

        // Mixed traffic
        for (int i = 0; i < 40; i++) begin
            step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
